// File: rtl/rs_driver.sv
`timescale 1ns/1ps
// Command-side driver/checker for a clocked RS flop: turns set/reset/hold/toggle
// requests into exclusive s/r pulses, then samples q/nq against an expected-state model.
module rs_driver #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    input  logic       q,
    input  logic       nq,
    output logic       done,
    output logic       err,
    output logic       illegal,
    output logic       exp_q,
    output logic [7:0] err_cnt
);

    localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [1:0] OP_HOLD = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SETTLE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s_nxt, r_nxt, exp_nxt;
    logic             done_nxt, err_nxt, illegal_nxt;
    logic [7:0]       err_cnt_nxt;
    logic             nexp, check_fail;

    function automatic logic next_exp(input logic [1:0] op, input logic cur);
        case (op)
            2'b00:   return 1'b1;
            2'b01:   return 1'b0;
            2'b10:   return cur;
            default: return ~cur;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign nexp       = next_exp(req_op, exp_q);
    assign check_fail = (q != exp_q) || (q == nq);
    assign req_ready  = (state == ST_IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        s_nxt       = s;
        r_nxt       = r;
        exp_nxt     = exp_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        illegal_nxt = 1'b0;
        err_cnt_nxt = err_cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    // Hold drives neither input; every other op drives toward nexp only.
                    exp_nxt   = nexp;
                    s_nxt     = (req_op != OP_HOLD) && nexp;
                    r_nxt     = (req_op != OP_HOLD) && !nexp;
                    cnt_nxt   = PULSE_LD;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = ST_SETTLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    done_nxt    = 1'b1;
                    err_nxt     = check_fail;
                    illegal_nxt = (q == nq);
                    if (check_fail)
                        err_cnt_nxt = sat_inc(err_cnt);
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            s       <= 1'b0;
            r       <= 1'b0;
            exp_q   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            illegal <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            s       <= s_nxt;
            r       <= r_nxt;
            exp_q   <= exp_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            illegal <= illegal_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

endmodule
